// File: rtl/ob_mk_queue.sv
// Ordered N-entry order queue (slot 0 = head) with insert/push/pop/fill/cancel and a running qty total.
// Latency: 1 cycle from command fire to registered response, flags, count and total.
// Backpressure: cmd_rdy drops while a response is held unaccepted (rsp_vld_r & ~rsp_rdy).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_vld/cmd_rdy          command handshake; cmd_op selects the operation
//   cmd_tbl/cmd_uid/cmd_qty  entry (INSERT/PUSH_HEAD), cancel key, fill amount
//   rsp_vld_r/rsp_rdy        response handshake; rsp_status_r/rsp_tbl_r/rsp_qty_r payload
//   head_vld_r/head_r        slot 0 view for the matching logic
//   cnt_r, full_r, empty_r, afull_r, qty_total_r   occupancy and running quantity total

package ob_pkg;
  typedef logic [15:0] uid_t;
  typedef logic [15:0] price_t;
  typedef logic [15:0] quantity_t;
  // Wide enough for quantity width + log2 of any practical depth (up to 256 entries).
  typedef logic [23:0] accum_quantity_t;

  typedef struct packed {
    uid_t      uid;
    price_t    price;
    quantity_t quantity;
  } table_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_INSERT = 3'd1;
  localparam logic [2:0] OP_PUSH   = 3'd2;
  localparam logic [2:0] OP_POP    = 3'd3;
  localparam logic [2:0] OP_FILL   = 3'd4;
  localparam logic [2:0] OP_CANCEL = 3'd5;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_MISS    = 3'd1;
  localparam logic [2:0] ST_FULL    = 3'd2;
  localparam logic [2:0] ST_EMPTY   = 3'd3;
  localparam logic [2:0] ST_EVICT   = 3'd4;
  localparam logic [2:0] ST_ILLEGAL = 3'd5;
endpackage

module ob_mk_queue
  import ob_pkg::*;
#(
  parameter int N         = 16,
  parameter int AFULL_LVL = N - 2,
  localparam int CW       = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_vld,
  output logic            cmd_rdy,
  input  logic [2:0]      cmd_op,
  input  table_t          cmd_tbl,
  input  uid_t            cmd_uid,
  input  quantity_t       cmd_qty,
  output logic            rsp_vld_r,
  input  logic            rsp_rdy,
  output logic [2:0]      rsp_status_r,
  output table_t          rsp_tbl_r,
  output quantity_t       rsp_qty_r,
  output logic            head_vld_r,
  output table_t          head_r,
  output logic [CW-1:0]   cnt_r,
  output logic            full_r,
  output logic            empty_r,
  output logic            afull_r,
  output accum_quantity_t qty_total_r
);

  // Slots at and above cnt_r are kept at '0, so head_r reads '0 whenever the queue is empty.
  table_t          slot_q [N];
  table_t          slot_n [N];
  logic [CW-1:0]   cnt_n;
  accum_quantity_t total_n;
  logic            rsp_gen;
  logic [2:0]      st_n;
  table_t          rtbl_n;
  quantity_t       rqty_n;
  logic            hit;
  int              hit_idx;
  table_t          hit_tbl;
  logic            fire;
  logic            is_full;
  logic            is_empty;

  assign cmd_rdy  = ~rsp_vld_r | rsp_rdy;
  assign fire     = cmd_vld & cmd_rdy;
  assign is_full  = (cnt_r == CW'(N));
  assign is_empty = (cnt_r == '0);
  assign head_r   = slot_q[0];

  always_comb begin
    slot_n  = slot_q;
    cnt_n   = cnt_r;
    total_n = qty_total_r;
    rsp_gen = 1'b0;
    st_n    = ST_OK;
    rtbl_n  = '0;
    rqty_n  = '0;
    hit     = 1'b0;
    hit_idx = 0;
    hit_tbl = '0;

    if (fire) begin
      rsp_gen = (cmd_op != OP_NOP);
      case (cmd_op)
        OP_NOP: ;
        OP_INSERT: begin
          if (is_full) begin
            st_n = ST_FULL;
          end else begin
            for (int i = 0; i < N; i++) begin
              if (CW'(i) == cnt_r) slot_n[i] = cmd_tbl;
            end
            cnt_n   = cnt_r + CW'(1);
            total_n = qty_total_r + accum_quantity_t'(cmd_tbl.quantity);
          end
        end
        OP_PUSH: begin
          for (int i = N - 1; i > 0; i--) slot_n[i] = slot_q[i-1];
          slot_n[0] = cmd_tbl;
          if (is_full) begin
            // Tail entry falls off; account for it in the same cycle as the push.
            st_n    = ST_EVICT;
            rtbl_n  = slot_q[N-1];
            total_n = qty_total_r + accum_quantity_t'(cmd_tbl.quantity)
                      - accum_quantity_t'(slot_q[N-1].quantity);
          end else begin
            cnt_n   = cnt_r + CW'(1);
            total_n = qty_total_r + accum_quantity_t'(cmd_tbl.quantity);
          end
        end
        OP_POP: begin
          if (is_empty) begin
            st_n = ST_EMPTY;
          end else begin
            rtbl_n = slot_q[0];
            for (int i = 0; i < N - 1; i++) slot_n[i] = slot_q[i+1];
            slot_n[N-1] = '0;
            cnt_n   = cnt_r - CW'(1);
            total_n = qty_total_r - accum_quantity_t'(slot_q[0].quantity);
          end
        end
        OP_FILL: begin
          if (is_empty) begin
            st_n   = ST_EMPTY;
            rqty_n = cmd_qty;
          end else begin
            rtbl_n = slot_q[0];
            if (cmd_qty < slot_q[0].quantity) begin
              slot_n[0].quantity = slot_q[0].quantity - cmd_qty;
              total_n = qty_total_r - accum_quantity_t'(cmd_qty);
            end else begin
              // Head fully consumed: remove it and hand back what is left of the fill.
              for (int i = 0; i < N - 1; i++) slot_n[i] = slot_q[i+1];
              slot_n[N-1] = '0;
              cnt_n   = cnt_r - CW'(1);
              rqty_n  = cmd_qty - slot_q[0].quantity;
              total_n = qty_total_r - accum_quantity_t'(slot_q[0].quantity);
            end
          end
        end
        OP_CANCEL: begin
          // Priority search from slot 0 so the oldest duplicate uid is removed first.
          for (int i = 0; i < N; i++) begin
            if (!hit && (CW'(i) < cnt_r) && (slot_q[i].uid == cmd_uid)) begin
              hit     = 1'b1;
              hit_idx = i;
              hit_tbl = slot_q[i];
            end
          end
          if (hit) begin
            rtbl_n = hit_tbl;
            for (int i = 0; i < N - 1; i++) begin
              if (i >= hit_idx) slot_n[i] = slot_q[i+1];
            end
            slot_n[N-1] = '0;
            cnt_n   = cnt_r - CW'(1);
            total_n = qty_total_r - accum_quantity_t'(hit_tbl.quantity);
          end else begin
            st_n = ST_MISS;
          end
        end
        default: st_n = ST_ILLEGAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) slot_q[i] <= '0;
      cnt_r        <= '0;
      qty_total_r  <= '0;
      head_vld_r   <= 1'b0;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      afull_r      <= 1'b0;
      rsp_vld_r    <= 1'b0;
      rsp_status_r <= '0;
      rsp_tbl_r    <= '0;
      rsp_qty_r    <= '0;
    end else begin
      // Next-state equals current state when nothing fires, so these update unconditionally.
      slot_q      <= slot_n;
      cnt_r       <= cnt_n;
      qty_total_r <= total_n;
      head_vld_r  <= (cnt_n != '0);
      empty_r     <= (cnt_n == '0);
      full_r      <= (cnt_n == CW'(N));
      afull_r     <= (cnt_n >= CW'(AFULL_LVL));
      if (rsp_gen) begin
        rsp_vld_r    <= 1'b1;
        rsp_status_r <= st_n;
        rsp_tbl_r    <= rtbl_n;
        rsp_qty_r    <= rqty_n;
      end else if (rsp_rdy) begin
        rsp_vld_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ob_mk_queue.sv
module tb_ob_mk_queue;
  import ob_pkg::*;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_vld;
  logic            cmd_rdy;
  logic [2:0]      cmd_op;
  table_t          cmd_tbl;
  uid_t            cmd_uid;
  quantity_t       cmd_qty;
  logic            rsp_vld_r;
  logic            rsp_rdy;
  logic [2:0]      rsp_status_r;
  table_t          rsp_tbl_r;
  quantity_t       rsp_qty_r;
  logic            head_vld_r;
  table_t          head_r;
  logic [CW-1:0]   cnt_r;
  logic            full_r;
  logic            empty_r;
  logic            afull_r;
  accum_quantity_t qty_total_r;

  ob_mk_queue #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
    .cmd_tbl(cmd_tbl), .cmd_uid(cmd_uid), .cmd_qty(cmd_qty),
    .rsp_vld_r(rsp_vld_r), .rsp_rdy(rsp_rdy), .rsp_status_r(rsp_status_r),
    .rsp_tbl_r(rsp_tbl_r), .rsp_qty_r(rsp_qty_r),
    .head_vld_r(head_vld_r), .head_r(head_r), .cnt_r(cnt_r),
    .full_r(full_r), .empty_r(empty_r), .afull_r(afull_r),
    .qty_total_r(qty_total_r)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: an ordered list of entries plus an integer running total.
  table_t mq[$];
  longint mtot = 0;

  logic [2:0] exp_st;
  table_t     exp_tbl;
  quantity_t  exp_qty;
  logic       exp_gen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic table_t mk(input int uid, input int qty);
    table_t t;
    t.uid      = uid_t'(uid);
    t.price    = price_t'(1000 + uid);
    t.quantity = quantity_t'(qty);
    return t;
  endfunction

  task automatic model(input logic [2:0] op, input table_t tbl, input uid_t uid, input quantity_t qty);
    table_t h;
    int     idx;
    exp_gen = (op != OP_NOP);
    exp_st  = ST_OK;
    exp_tbl = '0;
    exp_qty = '0;
    case (op)
      OP_NOP: ;
      OP_INSERT:
        if (mq.size() == N) exp_st = ST_FULL;
        else begin mq.push_back(tbl); mtot += tbl.quantity; end
      OP_PUSH: begin
        mq.push_front(tbl);
        mtot += tbl.quantity;
        if (mq.size() > N) begin
          exp_st  = ST_EVICT;
          exp_tbl = mq.pop_back();
          mtot   -= exp_tbl.quantity;
        end
      end
      OP_POP:
        if (mq.size() == 0) exp_st = ST_EMPTY;
        else begin exp_tbl = mq.pop_front(); mtot -= exp_tbl.quantity; end
      OP_FILL:
        if (mq.size() == 0) begin
          exp_st  = ST_EMPTY;
          exp_qty = qty;
        end else begin
          h       = mq[0];
          exp_tbl = h;
          if (qty < h.quantity) begin
            h.quantity = h.quantity - qty;
            mq[0] = h;
            mtot -= qty;
          end else begin
            void'(mq.pop_front());
            exp_qty = qty - exp_tbl.quantity;
            mtot   -= exp_tbl.quantity;
          end
        end
      OP_CANCEL: begin
        idx = -1;
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].uid == uid) idx = i;
        if (idx < 0) exp_st = ST_MISS;
        else begin
          exp_tbl = mq[idx];
          mq.delete(idx);
          mtot -= exp_tbl.quantity;
        end
      end
      default: exp_st = ST_ILLEGAL;
    endcase
  endtask

  task automatic check_state(input string tag);
    table_t eh;
    eh = (mq.size() > 0) ? mq[0] : '0;
    chk({tag, ":cnt"},   64'(cnt_r),       64'(mq.size()));
    chk({tag, ":total"}, 64'(qty_total_r), 64'(mtot));
    chk({tag, ":head"},  64'(head_r),      64'(eh));
    chk({tag, ":flags"}, {60'd0, head_vld_r, empty_r, full_r, afull_r},
        {60'd0, mq.size() > 0, mq.size() == 0, mq.size() == N, mq.size() >= N - 2});
  endtask

  task automatic do_cmd(input string tag, input logic [2:0] op, input table_t tbl,
                        input uid_t uid, input quantity_t qty);
    int n;
    @(negedge clk);
    cmd_op  = op;
    cmd_tbl = tbl;
    cmd_uid = uid;
    cmd_qty = qty;
    cmd_vld = 1'b1;
    n = 0;
    while (!cmd_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk({tag, ":rdy_timeout"}, 64'(cmd_rdy), 64'(1));
      cmd_vld = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
    model(op, tbl, uid, qty);
    chk({tag, ":rsp_vld"}, 64'(rsp_vld_r), 64'(exp_gen));
    if (exp_gen) begin
      chk({tag, ":status"}, 64'(rsp_status_r), 64'(exp_st));
      chk({tag, ":rsp_tbl"}, 64'(rsp_tbl_r), 64'(exp_tbl));
      chk({tag, ":rsp_qty"}, 64'(rsp_qty_r), 64'(exp_qty));
    end
    check_state(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_vld = 1'b0; cmd_op = '0; cmd_tbl = '0; cmd_uid = '0; cmd_qty = '0;
    rsp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst:empty", 64'(empty_r), 64'(1));
    chk("rst:cnt", 64'(cnt_r), 64'(0));
    chk("rst:cmd_rdy", 64'(cmd_rdy), 64'(1));
    chk("rst:rsp_vld", 64'(rsp_vld_r), 64'(0));
    chk("rst:total", 64'(qty_total_r), 64'(0));
    chk("rst:full", 64'(full_r), 64'(0));

    // Directed walk through fill, evict, partial fill and cancel corner cases.
    for (int i = 1; i <= 4; i++) do_cmd("ins", OP_INSERT, mk(i, 10 * i), '0, '0);
    do_cmd("ins_full", OP_INSERT, mk(5, 50), '0, '0);
    chk("ins_full:status", 64'(rsp_status_r), 64'(ST_FULL));
    chk("ins_full:total100", 64'(qty_total_r), 64'(100));
    chk("ins_full:full", 64'(full_r), 64'(1));
    do_cmd("push_evict", OP_PUSH, mk(9, 5), '0, '0);
    chk("push_evict:uid4", 64'(rsp_tbl_r.uid), 64'(4));
    chk("push_evict:total65", 64'(qty_total_r), 64'(65));
    do_cmd("fill8", OP_FILL, '0, '0, 16'd8);
    chk("fill8:rem3", 64'(rsp_qty_r), 64'(3));
    chk("fill8:head_uid1", 64'(head_r.uid), 64'(1));
    chk("fill8:total60", 64'(qty_total_r), 64'(60));
    do_cmd("fill4", OP_FILL, '0, '0, 16'd4);
    chk("fill4:head_qty6", 64'(head_r.quantity), 64'(6));
    do_cmd("cancel2", OP_CANCEL, '0, 16'd2, '0);
    chk("cancel2:cnt2", 64'(cnt_r), 64'(2));
    do_cmd("cancel7", OP_CANCEL, '0, 16'd7, '0);
    chk("cancel7:miss", 64'(rsp_status_r), 64'(ST_MISS));
    do_cmd("illegal", 3'd6, '0, '0, '0);
    do_cmd("nop", OP_NOP, '0, '0, '0);
    do_cmd("pop_a", OP_POP, '0, '0, '0);
    chk("pop_a:uid1", 64'(rsp_tbl_r.uid), 64'(1));
    do_cmd("pop_b", OP_POP, '0, '0, '0);
    chk("pop_b:uid3", 64'(rsp_tbl_r.uid), 64'(3));
    do_cmd("pop_empty", OP_POP, '0, '0, '0);
    do_cmd("fill_empty", OP_FILL, '0, '0, 16'd17);

    // Response held off for two cycles: command port must stall, payload must not move.
    @(posedge clk);
    @(negedge clk);
    rsp_rdy = 1'b0;
    do_cmd("bp_ins", OP_INSERT, mk(11, 7), '0, '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("bp:cmd_rdy", 64'(cmd_rdy), 64'(0));
      chk("bp:rsp_vld", 64'(rsp_vld_r), 64'(1));
      chk("bp:status", 64'(rsp_status_r), 64'(exp_st));
      check_state("bp");
    end
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp:release", 64'(rsp_vld_r), 64'(0));

    // Reset while a response is pending drops it and empties the queue.
    rsp_rdy = 1'b0;
    do_cmd("rr_ins", OP_INSERT, mk(12, 9), '0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    mtot = 0;
    rsp_rdy = 1'b1;
    chk("rr:rsp_vld", 64'(rsp_vld_r), 64'(0));
    check_state("rr");

    // Random op stream against the model; small uid range forces duplicates and misses.
    for (int k = 0; k < 400; k++) begin
      int r;
      logic [2:0] op;
      r = $urandom_range(0, 15);
      if (r < 5)       op = OP_INSERT;
      else if (r < 7)  op = OP_PUSH;
      else if (r < 9)  op = OP_POP;
      else if (r < 11) op = OP_FILL;
      else if (r < 13) op = OP_CANCEL;
      else if (r == 13) op = OP_NOP;
      else if (r == 14) op = 3'($urandom_range(6, 7));
      else             op = OP_POP;
      do_cmd("rnd", op, mk($urandom_range(1, 6), $urandom_range(1, 50)),
             uid_t'($urandom_range(1, 6)), quantity_t'($urandom_range(0, 60)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
